// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector: matches a run-time loaded 1..MAX_LEN bit
// pattern (overlapping or not). Optional match counter built when SEQ_MATCH_COUNT_EN is defined.
module seq_detect_prog #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0000_0001,
  parameter int                 RST_LEN     = 3,
  parameter bit                 RST_OVERLAP = 1'b1,
  localparam int                LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               count_clr,
  output logic               sequence_found,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  // The oldest history bit is only ever seen through hist_n, so it is never stored.
  logic [MAX_LEN-2:0] hist;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   len;
  logic [MAX_LEN-1:0] pat;
  logic               ovl;

  logic [MAX_LEN-1:0] hist_n;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_n;
  logic [LEN_W-1:0]   len_clamped;
  logic               match;

  always_comb begin
    // NOTE: every signal gets a value on every path through this block, so no latch is inferred.
    hist_n = {hist, in};
    fill_n = (fill >= MAX_LEN_L) ? MAX_LEN_L : fill + LEN_W'(1);
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
    match = in_valid && !cfg_we && (fill_n >= len) && (((hist_n ^ pat) & mask) == '0);

    if (cfg_len == '0) begin
      len_clamped = LEN_W'(1);
    end else if (cfg_len > MAX_LEN_L) begin
      len_clamped = MAX_LEN_L;
    end else begin
      len_clamped = cfg_len;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst) begin
      hist           <= '0;
      fill           <= '0;
      pat            <= RST_PATTERN;
      len            <= LEN_W'(RST_LEN);
      ovl            <= RST_OVERLAP;
      sequence_found <= 1'b0;
    end else begin
      sequence_found <= match;
      if (cfg_we) begin
        pat  <= cfg_pattern;
        len  <= len_clamped;
        ovl  <= cfg_overlap;
        hist <= '0;
        fill <= '0;
      end else if (in_valid) begin
        hist <= hist_n[MAX_LEN-2:0];
        // Non-overlapping mode restarts the fill so the next match needs len fresh bits.
        fill <= (match && !ovl) ? '0 : fill_n;
      end
    end
  end

`ifdef SEQ_MATCH_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      match_count <= '0;
    end else if (count_clr) begin
      match_count <= '0;
    end else if (match && (match_count != '1)) begin
      match_count <= match_count + CNT_W'(1);
    end
  end
`else
  logic count_clr_unused;
  assign count_clr_unused = count_clr;
  assign match_count      = '0;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Self-checking bench for seq_detect_prog: a directed vector table plus a
// hand-written idle-gap sequence. Counter expectations collapse to 0 without SEQ_MATCH_COUNT_EN.
module tb_seq_detect_prog;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               din = 1'b0;
  logic               cfg_we = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               count_clr = 1'b0;
  logic               sequence_found;
  logic [CNT_W-1:0]   match_count;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic               r;
    logic               vld;
    logic               d;
    logic               we;
    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   len;
    logic               ovl;
    logic               clr;
    logic               ef;
    int                 ec;
  } vec_t;

  vec_t vecs[$];

  seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in             (din),
    .cfg_we         (cfg_we),
    .cfg_pattern    (cfg_pattern),
    .cfg_len        (cfg_len),
    .cfg_overlap    (cfg_overlap),
    .count_clr      (count_clr),
    .sequence_found (sequence_found),
    .match_count    (match_count)
  );

  always #5 clk = ~clk;

  function automatic logic [CNT_W-1:0] exp_cnt(input int c);
`ifdef SEQ_MATCH_COUNT_EN
    return CNT_W'(c);
`else
    return CNT_W'(c) & '0;
`endif
  endfunction

  task automatic check(input string name, input int idx, input logic [7:0] actual,
                       input logic [7:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s @%0d: got %0h expected %0h", name, idx, actual, expected);
  endtask

  task automatic add(input logic r, vld, d, we, input logic [MAX_LEN-1:0] p,
                     input logic [LEN_W-1:0] l, input logic o, clr, ef, input int ec);
    vec_t v;
    v = '{r: r, vld: vld, d: d, we: we, pat: p, len: l, ovl: o, clr: clr, ef: ef, ec: ec};
    vecs.push_back(v);
  endtask

  task automatic acc(input logic d, ef, input int ec);
    add(1'b1, 1'b1, d, 1'b0, '0, '0, 1'b0, 1'b0, ef, ec);
  endtask

  task automatic cfg(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                     input logic o, clr, input int ec);
    add(1'b1, 1'b0, 1'b0, 1'b1, p, l, o, clr, 1'b0, ec);
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst = v.r; in_valid = v.vld; din = v.d; cfg_we = v.we;
    cfg_pattern = v.pat; cfg_len = v.len; cfg_overlap = v.ovl; count_clr = v.clr;
    @(posedge clk);
    #1;
    check("sequence_found", idx, 8'(sequence_found), 8'(v.ef));
    check("match_count", idx, 8'(match_count), 8'(exp_cnt(v.ec)));
  endtask

  initial begin
    vec_t v;
    bit   one_seen;

    // Reset to defaults: pattern 001, len 3, overlapping
    add(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 0);
    acc(0, 0, 0); acc(0, 0, 0); acc(1, 1, 1); acc(0, 0, 1);
    acc(0, 0, 1); acc(0, 0, 1); acc(1, 1, 2);
    add(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 0);

    // 1010 overlapping, then non-overlapping
    cfg(8'h0A, 4, 1'b1, 1'b0, 0);
    acc(1, 0, 0); acc(0, 0, 0); acc(1, 0, 0); acc(0, 1, 1); acc(1, 0, 1); acc(0, 1, 2);
    cfg(8'h0A, 4, 1'b0, 1'b0, 2);
    acc(1, 0, 2); acc(0, 0, 2); acc(1, 0, 2); acc(0, 1, 3); acc(1, 0, 3); acc(0, 0, 3);

    // Reconfigure mid-stream with a simultaneous bit, which must be discarded
    cfg(8'h01, 3, 1'b1, 1'b0, 3);
    acc(0, 0, 3); acc(0, 0, 3);
    add(1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 3, 1'b1, 1'b0, 1'b0, 3);
    acc(0, 0, 3); acc(0, 0, 3); acc(1, 1, 3);

    // Reset mid-stream under a non-default config restores 001/len3 and drops history
    cfg(8'h0A, 4, 1'b0, 1'b0, 3);
    acc(0, 0, 3); acc(0, 0, 3);
    add(1'b0, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 0);
    acc(1, 0, 0); acc(0, 0, 0); acc(0, 0, 0); acc(1, 1, 1);
    acc(0, 0, 1); acc(0, 0, 1);
    add(1'b1, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 0);

    // Five matches against a 2-bit saturating counter: 1,2,3,3,3
    for (int k = 1; k <= 5; k++) begin
      acc(0, 0, (k - 1 > 3) ? 3 : k - 1);
      acc(0, 0, (k - 1 > 3) ? 3 : k - 1);
      acc(1, 1, (k > 3) ? 3 : k);
    end

    // cfg_len 0 acts as 1; upper pattern bits are don't-care; consecutive pulses
    cfg(8'hF1, 0, 1'b1, 1'b1, 0);
    acc(1, 1, 1); acc(0, 0, 1); acc(1, 1, 2); acc(1, 1, 3); acc(1, 1, 3);
    add(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 3);

    // cfg_len above MAX_LEN clamps to a full 8-bit pattern
    cfg(8'hB3, 15, 1'b1, 1'b1, 0);
    acc(1, 0, 0); acc(0, 0, 0); acc(1, 0, 0); acc(1, 0, 0);
    acc(0, 0, 0); acc(0, 0, 0); acc(1, 0, 0); acc(1, 1, 1);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Idle gaps are transparent: 0,0,1 with three idle cycles between bits
    v = '{r: 1'b0, vld: 1'b0, d: 1'b0, we: 1'b0, pat: '0, len: '0, ovl: 1'b0, clr: 1'b0,
          ef: 1'b0, ec: 0};
    apply(v, 1000);
    one_seen = 1'b0;
    for (int b = 0; b < 3; b++) begin
      v.r = 1'b1; v.vld = 1'b1; v.d = (b == 2); v.ef = (b == 2); v.ec = (b == 2) ? 1 : 0;
      apply(v, 1001 + 4 * b);
      if (b == 2) one_seen = 1'b1;
      for (int g = 0; g < 3; g++) begin
        v.vld = 1'b0; v.d = 1'b1; v.ef = 1'b0; v.ec = one_seen ? 1 : 0;
        apply(v, 1002 + 4 * b + g);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
